mem_stream_src: RTL and testbench
=================================

Name: mem_stream_src

Overview:
- AXI4-Stream master that replays a small word buffer as one packet.
- Software/test logic loads the buffer through a simple write port, then pulses start.
- The block emits burst_len 32-bit beats on m_axis_mem_*, with tlast on the final beat.
- It is the transmit-side counterpart of the memory-dump stream sink and connects directly to its s_axis_mem_* inputs.

Parameters:
- DEPTH, 16, number of 32-bit words in the buffer; power of two, 2 to 256.
- AW, 4, address width; must equal log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  buffer write strobe.
- wr_addr  input  AW  buffer write address.
- wr_data  input  32  buffer write data (signed).
- start  input  1  one-cycle request to send a packet.
- burst_len  input  AW+1  beats to send; sampled with start.
- busy  output  1  high from the accepted start until the last beat is transferred.
- done  output  1  one-cycle pulse after the last beat is transferred.
- m_axis_mem_tdata  output  32  stream data (signed).
- m_axis_mem_tkeep  output  4  byte enables.
- m_axis_mem_tlast  output  1  final beat of the packet.
- m_axis_mem_tvalid  output  1  beat valid.
- m_axis_mem_tready  input  1  downstream ready.

Behaviour:
- Reset:
  - Asserting reset low asynchronously clears state to IDLE.
  - tvalid, tlast, busy and done go to 0; tdata goes to 0; tkeep goes to 4'hf.
  - Read index and beat counter go to 0.
  - Buffer contents are not reset and are retained across reset.
- Buffer:
  - Flop array. A write occurs on clk when wr_en=1 and busy=0.
  - Writes while busy=1 are dropped, so a packet in flight is never corrupted.
  - Read is combinational from the array into the output register.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - start=1 with burst_len!=0: latch len = min(burst_len, DEPTH), load tdata with buf[0], set tvalid=1, set tlast=(len==1), busy=1, go to SEND.
  - Latency: start sampled at edge N, so tvalid is high during cycle N+1.
  - start with burst_len=0 is ignored: no tvalid, no done, stays IDLE.
- SEND:
  - A beat transfers on an edge where tvalid=1 and tready=1.
  - If the transferred beat was not last: load the next word buf[idx+1] and update tlast (1 when idx+1 == len-1).
  - If it was last: tvalid=0, tlast=0, go to DONE.
  - If tready=0: tdata, tlast and tvalid hold stable (AXI rule). tvalid never deasserts without a transfer.
  - With tready held at 1 the block sends one beat per cycle, so the packet occupies exactly len consecutive cycles.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- start while busy or in DONE is ignored; it is not queued.
- tkeep is constant 4'hf, since every beat is a full word.
- Index counter is AW+1 bits; no wrap-around within a packet because len<=DEPTH.
- Reset mid-packet: the packet is truncated with no tlast. tvalid drops asynchronously. The next start begins again at buf[0].

Optional Feature:
- Macro: MEM_SRC_RAMP_EN.
- When defined:
  - Adds input port ramp_sel (1 bit), sampled with start.
  - If ramp_sel=1, beat k carries tdata = k (0,1,2,...) instead of buf[k].
  - All handshake, length and tlast rules are unchanged.
  - The buffer is untouched.
- When undefined: no ramp_sel port exists, and data always comes from the buffer.

Test Plan:
- Continuous burst:
  - Stimulus: write buf[0..3]=10,-20,30,-40; start with burst_len=4; tready=1.
  - Response: beats 10,-20,30,-40 on 4 consecutive cycles starting 1 cycle after start; tlast only on -40; tkeep=4'hf; done one cycle after the last beat; busy=1 throughout.
- Backpressure:
  - Stimulus: same load, burst_len=3; tready pattern 1,0,0,1,0,1.
  - Response: tdata/tlast stable while tready=0; exactly 3 transfers (10,-20,30); tlast with 30; no duplicated or skipped beat.
- Length edge cases:
  - Stimulus: burst_len=0; then burst_len=1; then burst_len=DEPTH+... clamp case with burst_len=31 and DEPTH=16.
  - Response: burst_len=0 gives no activity; burst_len=1 gives a single beat with tlast=1; burst_len=31 gives 16 beats with tlast on beat 16.
- Blocked writes and starts:
  - Stimulus: during a 4-beat burst, write buf[2]=99 and pulse start again.
  - Response: beat 2 is still 30; the second start is ignored; after done, buf[2] reads 30 on the next packet.
- Reset mid-packet:
  - Stimulus: assert reset low mid-packet, asynchronously to clk, after beat 1 is transferred.
  - Response: tvalid=0, busy=0 and done=0 immediately; after release, a new start sends from buf[0] with the buffer contents intact.
- Ramp mode (MEM_SRC_RAMP_EN defined):
  - Stimulus: ramp_sel=1, burst_len=5, tready=1.
  - Response: tdata 0,1,2,3,4; tlast on 4.

Source files
------------

// File: rtl/mem_stream_src_if.sv
// rtl/mem_stream_src_if.sv - packet stream bundle between mem_stream_src and a memory-dump sink
interface mem_stream_src_if;
    logic signed [31:0] tdata;
    logic [3:0]         tkeep;
    logic               tlast;
    logic               tvalid;
    logic               tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/mem_stream_src.sv
// rtl/mem_stream_src.sv - replays a small word buffer as one stream packet (optional MEM_SRC_RAMP_EN)
module mem_stream_src #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic signed [31:0]   wr_data,
    input  logic                 start,
    input  logic [AW:0]          burst_len,
`ifdef MEM_SRC_RAMP_EN
    input  logic                 ramp_sel,
`endif
    output logic                 busy,
    output logic                 done,
    mem_stream_src_if.master     m_axis_mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

    state_t             state_q, state_d;
    logic signed [31:0] tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic [AW:0]        idx_q, idx_d;
    logic [AW:0]        len_q, len_d;
    logic [AW:0]        idx_nxt;
    logic [AW:0]        start_len;
    logic               start_ramp;
    logic               ramp_q;

    logic signed [31:0] mem_q [DEPTH];

    assign busy = (state_q == SEND);
    assign done = (state_q == DONE);

    assign m_axis_mem.tdata  = tdata_q;
    assign m_axis_mem.tkeep  = 4'hf;
    assign m_axis_mem.tlast  = tlast_q;
    assign m_axis_mem.tvalid = tvalid_q;

    // Buffer is deliberately outside reset so a loaded pattern survives a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

`ifdef MEM_SRC_RAMP_EN
    assign start_ramp = ramp_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ramp_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            ramp_q <= ramp_sel;
        end
    end
`else
    assign start_ramp = 1'b0;
    assign ramp_q     = 1'b0;
`endif

    assign start_len = (burst_len > LEN_MAX) ? LEN_MAX : burst_len;
    assign idx_nxt   = idx_q + LEN_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            idx_q    <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        idx_d    = idx_q;
        len_d    = len_q;

        unique case (state_q)
            IDLE: begin
                if (start && burst_len != '0) begin
                    len_d    = start_len;
                    idx_d    = '0;
                    tdata_d  = start_ramp ? 32'sd0 : mem_q[0];
                    tvalid_d = 1'b1;
                    tlast_d  = (start_len == LEN_ONE);
                    state_d  = SEND;
                end
            end
            SEND: begin
                // tvalid is always high here, so tready alone marks a transfer.
                if (m_axis_mem.tready) begin
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = DONE;
                    end else begin
                        idx_d   = idx_nxt;
                        tdata_d = ramp_q ? 32'(idx_nxt) : mem_q[idx_nxt[AW-1:0]];
                        tlast_d = (idx_nxt == len_q - LEN_ONE);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stream_src.sv
// tb/tb_mem_stream_src.sv - directed self-checking bench for mem_stream_src
module tb_mem_stream_src;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               wr_en = 1'b0;
    logic [AW-1:0]      wr_addr = '0;
    logic signed [31:0] wr_data = '0;
    logic               start = 1'b0;
    logic [AW:0]        burst_len = '0;
`ifdef MEM_SRC_RAMP_EN
    logic               ramp_sel = 1'b0;
`endif
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stream_src_if bus();

    mem_stream_src #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .burst_len  (burst_len),
`ifdef MEM_SRC_RAMP_EN
        .ramp_sel   (ramp_sel),
`endif
        .busy       (busy),
        .done       (done),
        .m_axis_mem (bus)
    );

    always #5 clk = ~clk;

    task automatic write_word(input int a, input int d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a[AW-1:0];
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start(input int len);
        @(negedge clk);
        start     = 1'b1;
        burst_len = len[AW:0];
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic test_reset;
        bus.tready = 1'b0;
        #12;
        n_checks++; if (bus.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", bus.tvalid); end
        n_checks++; if (bus.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b expected 0", bus.tlast); end
        n_checks++; if (bus.tdata !== 32'sd0) begin n_fail++; $display("FAIL reset_tdata: got %0d expected 0", bus.tdata); end
        n_checks++; if (bus.tkeep !== 4'hf) begin n_fail++; $display("FAIL reset_tkeep: got %h expected f", bus.tkeep); end
        n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); end
        @(negedge clk);
        reset = 1'b1;
        write_word(0, 10);
        write_word(1, -20);
        write_word(2, 30);
        write_word(3, -40);
    endtask

    task automatic test_continuous;
        int exp_d[4] = '{10, -20, 30, -40};
        bus.tready = 1'b1;
        pulse_start(4);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (bus.tvalid !== 1'b1) begin n_fail++; $display("FAIL cont_tvalid beat %0d: got %b expected 1", k, bus.tvalid); end
            n_checks++; if (bus.tdata !== exp_d[k]) begin n_fail++; $display("FAIL cont_tdata beat %0d: got %0d expected %0d", k, bus.tdata, exp_d[k]); end
            n_checks++; if (bus.tlast !== (k == 3)) begin n_fail++; $display("FAIL cont_tlast beat %0d: got %b expected %b", k, bus.tlast, (k == 3)); end
            n_checks++; if (bus.tkeep !== 4'hf) begin n_fail++; $display("FAIL cont_tkeep beat %0d: got %h expected f", k, bus.tkeep); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cont_busy beat %0d: got %b expected 1", k, busy); end
            @(negedge clk);
        end
        n_checks++; if ({done, busy, bus.tvalid} !== 3'b100) begin n_fail++; $display("FAIL cont_done: got done/busy/tvalid %b expected 100", {done, busy, bus.tvalid}); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL cont_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_backpressure;
        bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int exp_d[3] = '{10, -20, 30};
        int got_d[$];
        bit got_l[$];
        bit hold = 1'b0;
        logic signed [31:0] prev_d = '0;
        logic prev_l = 1'b0;
        bus.tready = 1'b0;
        pulse_start(3);
        for (int c = 0; c < 6; c++) begin
            if (hold) begin
                n_checks++; if (bus.tdata !== prev_d || bus.tlast !== prev_l) begin n_fail++; $display("FAIL bp_stable cycle %0d: got %0d/%b expected %0d/%b", c, bus.tdata, bus.tlast, prev_d, prev_l); end
                n_checks++; if (bus.tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_tvalid_hold cycle %0d: got %b expected 1", c, bus.tvalid); end
            end
            bus.tready = pat[c];
            if (bus.tvalid && pat[c]) begin
                got_d.push_back(bus.tdata);
                got_l.push_back(bus.tlast);
            end
            hold   = bus.tvalid && !pat[c];
            prev_d = bus.tdata;
            prev_l = bus.tlast;
            @(negedge clk);
        end
        n_checks++; if (got_d.size() !== 3) begin n_fail++; $display("FAIL bp_count: got %0d expected 3", got_d.size()); end
        for (int i = 0; i < 3 && i < got_d.size(); i++) begin
            n_checks++; if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 2)) begin n_fail++; $display("FAIL bp_beat %0d: got %0d/%b expected %0d/%b", i, got_d[i], got_l[i], exp_d[i], (i == 2)); end
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b expected 1", done); end
        bus.tready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_length_edges;
        int base[4] = '{10, -20, 30, -40};
        int cnt = 0;
        int guard = 0;
        int exp_v;
        bus.tready = 1'b1;
        pulse_start(0);
        for (int c = 0; c < 3; c++) begin
            n_checks++; if ({bus.tvalid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL len0_idle cycle %0d: got %b expected 000", c, {bus.tvalid, busy, done}); end
            @(negedge clk);
        end
        pulse_start(1);
        n_checks++; if (bus.tvalid !== 1'b1 || bus.tlast !== 1'b1 || bus.tdata !== 32'sd10) begin n_fail++; $display("FAIL len1_beat: got %b/%b/%0d expected 1/1/10", bus.tvalid, bus.tlast, bus.tdata); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || bus.tvalid !== 1'b0) begin n_fail++; $display("FAIL len1_done: got %b/%b expected 1/0", done, bus.tvalid); end
        for (int i = 4; i < DEPTH; i++) write_word(i, 100 + i);
        pulse_start(31);
        while (bus.tvalid === 1'b1 && guard < 40) begin
            exp_v = (cnt < 4) ? base[cnt] : 100 + cnt;
            n_checks++; if (bus.tdata !== exp_v || bus.tlast !== (cnt == DEPTH - 1)) begin n_fail++; $display("FAIL clamp_beat %0d: got %0d/%b expected %0d/%b", cnt, bus.tdata, bus.tlast, exp_v, (cnt == DEPTH - 1)); end
            cnt++;
            guard++;
            @(negedge clk);
        end
        n_checks++; if (cnt !== DEPTH) begin n_fail++; $display("FAIL clamp_count: got %0d expected %0d", cnt, DEPTH); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL clamp_done: got %b expected 1", done); end
        @(negedge clk);
    endtask

    task automatic test_blocked;
        int exp_d[4] = '{10, -20, 30, -40};
        bus.tready = 1'b1;
        pulse_start(4);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (bus.tdata !== exp_d[k] || bus.tvalid !== 1'b1) begin n_fail++; $display("FAIL blk_beat %0d: got %0d/%b expected %0d/1", k, bus.tdata, bus.tvalid, exp_d[k]); end
            if (k == 0) begin
                wr_en = 1'b1; wr_addr = 4'd2; wr_data = 99;
                start = 1'b1; burst_len = 5'd4;
            end else if (k == 1) begin
                wr_en = 1'b0; start = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL blk_done: got %b expected 1", done); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if ({bus.tvalid, busy} !== 2'b00) begin n_fail++; $display("FAIL blk_no_restart cycle %0d: got %b expected 00", c, {bus.tvalid, busy}); end
        end
        pulse_start(3);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (bus.tdata !== exp_d[k]) begin n_fail++; $display("FAIL blk_reread %0d: got %0d expected %0d", k, bus.tdata, exp_d[k]); end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bus.tready = 1'b1;
        pulse_start(4);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++; if ({bus.tvalid, busy, done, bus.tlast} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_clear: got tvalid/busy/done/tlast %b expected 0000", {bus.tvalid, busy, done, bus.tlast}); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %b expected 0", bus.tvalid); end
        pulse_start(2);
        n_checks++; if (bus.tdata !== 32'sd10 || bus.tlast !== 1'b0) begin n_fail++; $display("FAIL rstmid_beat0: got %0d/%b expected 10/0", bus.tdata, bus.tlast); end
        @(negedge clk);
        n_checks++; if (bus.tdata !== -32'sd20 || bus.tlast !== 1'b1) begin n_fail++; $display("FAIL rstmid_beat1: got %0d/%b expected -20/1", bus.tdata, bus.tlast); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rstmid_done: got %b expected 1", done); end
        @(negedge clk);
    endtask

`ifdef MEM_SRC_RAMP_EN
    task automatic test_ramp;
        bus.tready = 1'b1;
        ramp_sel = 1'b1;
        pulse_start(5);
        ramp_sel = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (bus.tdata !== k || bus.tlast !== (k == 4) || bus.tvalid !== 1'b1) begin n_fail++; $display("FAIL ramp_beat %0d: got %0d/%b expected %0d/%b", k, bus.tdata, bus.tlast, k, (k == 4)); end
            @(negedge clk);
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ramp_done: got %b expected 1", done); end
        pulse_start(1);
        n_checks++; if (bus.tdata !== 32'sd10) begin n_fail++; $display("FAIL ramp_buffer_kept: got %0d expected 10", bus.tdata); end
        @(negedge clk);
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset;
        test_continuous;
        test_backpressure;
        test_length_edges;
        test_blocked;
        test_reset_mid;
`ifdef MEM_SRC_RAMP_EN
        test_ramp;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
